// File: rtl/time_display_scan.sv
// Six-digit multiplexed seven-segment scan of the HH:MM:SS time registers.
// Frames come from a snapshot taken at frame start; the edited field blinks.
module time_display_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic [1:0] field,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [2:0] SET_TIME = 3'b010;

  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blk_cnt;
  logic          blink_vis;
  logic [2:0]    idx;
  logic [2:0]    idx_nxt;
  logic [4:0]    snap_h;
  logic [5:0]    snap_m;
  logic [5:0]    snap_s;
  logic [2:0]    prev_state;
  logic [1:0]    prev_field;

  logic       tick;
  logic       wrap;
  logic       restart;
  logic [5:0] f_val;
  logic       f_ok;
  logic [1:0] f_id;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_nxt;
  logic [5:0] an_nxt;
  logic       dp_nxt;

  always_comb begin
    tick    = ref_cnt == R_LAST;
    wrap    = idx == 3'd0;
    idx_nxt = wrap ? 3'd5 : idx - 3'd1;
    restart = (state != prev_state) || (field != prev_field);
    f_val   = '0;
    f_ok    = 1'b1;
    f_id    = 2'd0;
    // The first digit of a frame must use the values being captured now.
    case (idx_nxt)
      3'd5, 3'd4: begin
        f_id  = 2'd0;
        f_val = wrap ? {1'b0, hours} : {1'b0, snap_h};
        f_ok  = f_val <= 6'd23;
      end
      3'd3, 3'd2: begin
        f_id  = 2'd1;
        f_val = wrap ? minutes : snap_m;
        f_ok  = f_val <= 6'd59;
      end
      default: begin
        f_id  = 2'd2;
        f_val = wrap ? seconds : snap_s;
        f_ok  = f_val <= 6'd59;
      end
    endcase
    digit = idx_nxt[0] ? 4'(f_val / 6'd10) : 4'(f_val % 6'd10);
    blank = (state == SET_TIME) && (field == f_id) && !blink_vis;
    case (digit)
      4'd0:    seg_nxt = 7'b1000000;
      4'd1:    seg_nxt = 7'b1111001;
      4'd2:    seg_nxt = 7'b0100100;
      4'd3:    seg_nxt = 7'b0110000;
      4'd4:    seg_nxt = 7'b0011001;
      4'd5:    seg_nxt = 7'b0010010;
      4'd6:    seg_nxt = 7'b0000010;
      4'd7:    seg_nxt = 7'b1111000;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0010000;
      default: seg_nxt = 7'b0111111;
    endcase
    if (!f_ok) seg_nxt = 7'b0111111;
    if (blank) seg_nxt = 7'b1111111;
    an_nxt = ~(6'b000001 << idx_nxt);
    dp_nxt = blank | ~((idx_nxt == 3'd4) | (idx_nxt == 3'd2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      idx     <= 3'd5;
      snap_h  <= '0;
      snap_m  <= '0;
      snap_s  <= '0;
      an      <= 6'b111111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
      if (tick) begin
        idx <= idx_nxt;
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= dp_nxt;
        if (wrap) begin
          snap_h <= hours;
          snap_m <= minutes;
          snap_s <= seconds;
        end
      end
    end
  end

  // Any mode or field change restarts the blink with the digits shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt    <= '0;
      blink_vis  <= 1'b1;
      prev_state <= 3'b000;
      prev_field <= 2'd3;
    end else begin
      prev_state <= state;
      prev_field <= field;
      if (restart) begin
        blk_cnt   <= '0;
        blink_vis <= 1'b1;
      end else if (blk_cnt == B_LAST) begin
        blk_cnt   <= '0;
        blink_vis <= ~blink_vis;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

endmodule
